// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared constants and helper functions for the branch
//                predictor table (counter limits, 2-bit counter state names,
//                gshare index computation).
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

    // Widest PC / history the index helper accepts; callers zero-extend into it.
    localparam int BP_ARG_W = 64;

    // Named states of a 2-bit saturating counter.
    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    // Largest value a saturating counter of cnt_w bits can hold.
    function automatic int CNT_MAX(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // gshare index: word-aligned PC bits XOR the zero-extended history,
    // reduced modulo 2^idx_w so upper PC bits simply alias.
    function automatic logic [BP_ARG_W-1:0] bp_index(
        input logic [BP_ARG_W-1:0] pc,
        input logic [BP_ARG_W-1:0] ghr,
        input int                  idx_w = BP_ARG_W
    );
        logic [BP_ARG_W-1:0] mask;
        if (idx_w >= BP_ARG_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << idx_w) - 64'd1;
        end
        return ((pc >> 2) ^ ghr) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Next-value logic for a WIDTH-bit saturating up/down counter.
//                Counts up on inc=1, down on inc=0, holds at 0 and at the
//                maximum, and passes the current value through when en=0.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter
    import bp_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             en,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(CNT_MAX(WIDTH));

    // Saturating step in the requested direction; limits hold their value.
    always_comb begin
        nxt = cur;
        if (en) begin
            if (inc && (cur != c_max)) begin
                nxt = cur + 1'b1;
            end else if (!inc && (cur != '0)) begin
                nxt = cur - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_table
//  Description : gshare / bimodal branch predictor. A table of 2^IDX_W
//                saturating counters is indexed by PC[IDX_W+1:2] XOR a global
//                history register. Lookup is combinational; the resolved
//                outcome returns with the lookup index and trains the entry,
//                shifts the history and counts mispredictions.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 2,
    parameter int HIST_W   = 4,
    parameter int INIT_CNT = (1 << CNT_W) - 1,
    parameter int MISS_W   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [PC_W-1:0]                       lookup_pc_i,
    output logic                                  predict_o,
    output logic [IDX_W-1:0]                      lookup_idx_o,
    input  logic                                  upd_valid_i,
    input  logic [IDX_W-1:0]                      upd_idx_i,
    input  logic                                  upd_taken_i,
    input  logic                                  upd_pred_i,
    output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] hist_o,
    output logic [MISS_W-1:0]                     miss_cnt_o
);

    localparam int               c_entries  = 1 << IDX_W;
    localparam logic [CNT_W-1:0] c_init     = CNT_W'(INIT_CNT);
    localparam logic [MISS_W-1:0] c_miss_max = '1;

    // Counter table; a plain register array so lookup is a direct mux read.
    logic [CNT_W-1:0]  r_table [c_entries];
    logic [MISS_W-1:0] r_miss_cnt;

    logic [IDX_W-1:0]  w_ghr_idx;       // history zero-extended to index width
    logic [IDX_W-1:0]  w_lookup_idx;
    logic [CNT_W-1:0]  w_lookup_entry;
    logic [CNT_W-1:0]  w_upd_cur;
    logic [CNT_W-1:0]  w_upd_nxt;
    logic              w_mispredict;

    // ------------------------------------------------------------------------
    // Global history register. Absent entirely in bimodal configurations.
    // ------------------------------------------------------------------------
    generate
        if (HIST_W == 0) begin : g_bimodal
            assign w_ghr_idx = '0;
            assign hist_o    = 1'b0;
        end else begin : g_gshare
            logic [HIST_W-1:0] r_ghr;
            logic [HIST_W-1:0] w_ghr_nxt;

            if (HIST_W == 1) begin : g_ghr_single
                assign w_ghr_nxt = upd_taken_i;
            end else begin : g_ghr_shift
                assign w_ghr_nxt = {r_ghr[HIST_W-2:0], upd_taken_i};
            end

            // History advances only when a branch resolves (non-speculative).
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_ghr <= '0;
                end else if (upd_valid_i) begin
                    r_ghr <= w_ghr_nxt;
                end
            end

            assign w_ghr_idx = IDX_W'(r_ghr);
            assign hist_o    = r_ghr;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Lookup: read-before-write, so a same-cycle update is not bypassed.
    // ------------------------------------------------------------------------
    assign w_lookup_idx   = IDX_W'(bp_index(BP_ARG_W'(lookup_pc_i),
                                            BP_ARG_W'(w_ghr_idx), IDX_W));
    assign w_lookup_entry = r_table[w_lookup_idx];
    assign lookup_idx_o   = w_lookup_idx;
    assign predict_o      = w_lookup_entry[CNT_W-1];

    // ------------------------------------------------------------------------
    // Update path: one shared counter stepper feeds the addressed entry.
    // ------------------------------------------------------------------------
    assign w_upd_cur = r_table[upd_idx_i];

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_upd_counter (
        .cur (w_upd_cur),
        .inc (upd_taken_i),
        .en  (upd_valid_i),
        .nxt (w_upd_nxt)
    );

    // Table write; the index is only used when the update is qualified valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_entries; i++) begin
                r_table[i] <= c_init;
            end
        end else if (upd_valid_i) begin
            r_table[upd_idx_i] <= w_upd_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Misprediction counter, saturating at all-ones.
    // ------------------------------------------------------------------------
    assign w_mispredict = upd_valid_i && (upd_pred_i != upd_taken_i);

    // Count resolved branches whose original prediction was wrong.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_miss_cnt <= '0;
        end else if (w_mispredict && (r_miss_cnt != c_miss_max)) begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign miss_cnt_o = r_miss_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised successor to the single 2-bit saturating-counter branch predictor.
- Holds a table of 2^IDX_W saturating counters, each CNT_W bits wide.
- Indexes the table with PC bits XOR a global history register (GHR), gshare-style; HIST_W=0 gives pure bimodal.
- Sits in the IF/ID stage. The index used at lookup travels down the pipeline and returns with the resolved outcome from EX. The block also counts mispredictions.

Parameters:
- PC_W, 32, program-counter width.
- IDX_W, 4, table index width; 2^IDX_W entries.
- CNT_W, 2, saturating counter width; legal range 1..4.
- HIST_W, 4, GHR length; legal range 0..IDX_W; 0 means bimodal.
- INIT_CNT, 2^CNT_W-1, counter value after reset (strongly taken).
- MISS_W, 16, misprediction counter width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- lookup_pc_i  in  PC_W  PC of the instruction being fetched or decoded.
- predict_o  out  1  prediction: MSB of the indexed counter (1 = taken).
- lookup_idx_o  out  IDX_W  index used for predict_o; the pipeline carries it to the update.
- upd_valid_i  in  1  a branch resolved this cycle.
- upd_idx_i  in  IDX_W  index returned from lookup_idx_o of that branch.
- upd_taken_i  in  1  actual branch outcome.
- upd_pred_i  in  1  prediction originally made for that branch.
- hist_o  out  max(HIST_W,1)  current GHR; reads 0 when HIST_W=0.
- miss_cnt_o  out  MISS_W  total mispredictions since reset.

Behaviour:
- Clock and reset:
  - Single clock, clk_i.
  - Reset is synchronous and active-high on rst_i; it is sampled only at posedge clk_i.
  - While rst_i=1, the table, GHR and miss counter take their reset values at each clock edge, and upd_valid_i is ignored.
- Reset values:
  - Every table entry = INIT_CNT.
  - GHR = 0, miss_cnt_o = 0.
  - Immediately after reset, predict_o = INIT_CNT[CNT_W-1] = 1 and lookup_idx_o = lookup_pc_i[IDX_W+1:2].
- Lookup (combinational, zero latency):
  - idx = lookup_pc_i[IDX_W+1:2] XOR {zeros, GHR}, with the GHR zero-extended to IDX_W.
  - lookup_idx_o = idx.
  - predict_o = table[idx][CNT_W-1].
- Update (one cycle, when upd_valid_i=1 and rst_i=0):
  - If upd_taken_i=1 and table[upd_idx_i] < 2^CNT_W-1, increment the entry.
  - If upd_taken_i=0 and table[upd_idx_i] > 0, decrement the entry.
  - An entry at its limit holds its value.
  - GHR <= {GHR[HIST_W-2:0], upd_taken_i}. When HIST_W=1 the GHR simply loads upd_taken_i.
  - If upd_pred_i != upd_taken_i, miss_cnt_o increments and saturates at 2^MISS_W-1.
- No update (upd_valid_i=0): table, GHR and miss counter hold.
- Simultaneous lookup and update to the same index:
  - predict_o reflects the pre-update entry (read-before-write; no bypass).
  - The lookup index uses the pre-update GHR.
- The GHR is updated non-speculatively, at resolution only. Flushes need no recovery input.
- Wrap-around: index arithmetic is IDX_W bits modulo 2^IDX_W. PC bits above IDX_W+1 alias.
- Reset asserted while upd_valid_i=1: reset wins and the update is lost.
- X-safety: the table and GHR are never written from an unqualified upd_idx_i.

Decomposition:
- Package bp_pkg:
  - CNT_MAX(CNT_W) function.
  - For CNT_W=2, the state constants STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
  - Index function bp_index(pc, ghr).
- Sub-module sat_counter: parametrised by width; inputs cur, inc, en; output nxt.
  - Instantiated once on the update path (not per entry); the table itself is a register array in the top level.

Test Plan:
1. Reset, defaults (IDX_W=4, HIST_W=4): assert rst_i for 1 cycle, lookup_pc_i=0x40 -> predict_o=1, lookup_idx_o=0x0, hist_o=0, miss_cnt_o=0.
2. Saturation down: 4 updates to idx 3 with taken=0, pred=1 -> entry goes 3,2,1,0,0. predict_o for that index=0 after the 2nd update. miss_cnt_o=4. hist_o=0.
3. Saturation up: from entry 0, 4 taken updates -> 1,2,3,3. The entry holds at 3; no wrap to 0.
4. GHR indexing: updates taken 1,0,1,1 -> hist_o=0xB. lookup_pc_i=0x04 gives lookup_idx_o=0x1^0xB=0xA.
5. Same-cycle collision: lookup and update both target idx 5 (entry 2, taken=0) -> predict_o=1 in that cycle, 0 on the next.
6. Reset mid-stream: rst_i=1 together with upd_valid_i=1 -> all entries back to 3, GHR=0, miss_cnt_o=0; the update is ignored. Repeat with HIST_W=0 to confirm the index equals the PC bits only.
